// File: rtl/disp_pkg.sv
// Shared types for the 8-digit seven-segment display path (scan controller,
// anode decoder, segment encoder).
package disp_pkg;

  localparam int N_DIGITS = 8;
  localparam int SEL_W    = 3;

  typedef logic [SEL_W-1:0] digit_idx_t;
  typedef logic [3:0]       nibble_t;

  // Nibble i of a packed 8-digit hex word.
  function automatic nibble_t get_nibble(input logic [31:0] word, input digit_idx_t idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/digit_ring_search.sv
// Combinational circular priority search: finds the first enabled digit after
// `cur`, wrapping 7 -> 0 and ending at `cur` itself.
module digit_ring_search
  import disp_pkg::*;
(
  input  digit_idx_t            cur,
  input  logic [N_DIGITS-1:0]   digit_en,
  output digit_idx_t            next,
  output logic                  wrap,
  output logic                  none
);

  digit_idx_t idx;

  always_comb begin
    next = cur;
    none = 1'b1;
    idx  = cur;
    // Scan from farthest to nearest so the nearest enabled index wins;
    // offset N_DIGITS aliases to cur, the lowest-priority candidate.
    for (int i = N_DIGITS; i >= 1; i--) begin
      idx = cur + digit_idx_t'(i);
      if (digit_en[idx]) begin
        next = idx;
        none = 1'b0;
      end
    end
    wrap = ~none & (next <= cur);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the 8-digit seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN adds leading-zero blanking.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int PRESCALE = 100_000,
  parameter int N        = SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          value,
  input  logic [N_DIGITS-1:0]  digit_en,
  input  logic [N_DIGITS-1:0]  dp_in,
  output logic [N-1:0]         sel,
  output logic [3:0]           digit,
  output logic                 blank,
  output logic                 dp,
  output logic                 frame
);

  localparam int                CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  digit_idx_t          sel_q, sel_d;
  nibble_t             digit_q, digit_d;
  logic                blank_q, blank_d;
  logic                dp_q, dp_d;
  logic                frame_q, frame_d;

  logic                tick;
  digit_idx_t          ring_next;
  logic                ring_wrap;
  logic                ring_none;
  logic [N_DIGITS-1:0] lz_blank;

  digit_ring_search u_ring (
    .cur      (sel_q),
    .digit_en (digit_en),
    .next     (ring_next),
    .wrap     (ring_wrap),
    .none     (ring_none)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i blanks when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      lz_blank[i] = ((value >> (4 * i)) == 32'd0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;

    // With nothing enabled the search returns cur, so sel simply holds.
    sel_d   = tick ? ring_next : sel_q;
    frame_d = tick & ring_wrap & ~ring_none;

    // Data outputs follow sel_d so they stay aligned with the registered sel.
    digit_d = get_nibble(value, sel_d);
    dp_d    = dp_in[sel_d];
    blank_d = ~digit_en[sel_d] | lz_blank[sel_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      digit_q <= '0;
      blank_q <= 1'b1;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign sel   = sel_q;
  assign digit = digit_q;
  assign blank = blank_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=4; inputs driven and
// outputs sampled on the falling clock edge.
module tb_display_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [2:0]  sel;
  logic [3:0]  digit;
  logic        blank;
  logic        dp;
  logic        frame;

  int tests;
  int fails;

  logic [2:0] exp_q[$];

  display_scan_ctrl #(.PRESCALE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .digit_en (digit_en),
    .dp_in    (dp_in),
    .sel      (sel),
    .digit    (digit),
    .blank    (blank),
    .dp       (dp),
    .frame    (frame)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset across exactly one rising edge; returns on a falling edge
  // with the DUT in its reset state (cycle count 0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    value    = 32'h7654_3219;
    digit_en = 8'hFF;
    dp_in    = 8'hFF;
    do_reset();
    tests++; if (sel !== 3'd0)   begin fails++; $display("FAIL reset_sel got %0d expected 0", sel); end
    tests++; if (digit !== 4'd0) begin fails++; $display("FAIL reset_digit got %0h expected 0", digit); end
    tests++; if (blank !== 1'b1) begin fails++; $display("FAIL reset_blank got %0b expected 1", blank); end
    tests++; if (dp !== 1'b0)    begin fails++; $display("FAIL reset_dp got %0b expected 0", dp); end
    tests++; if (frame !== 1'b0) begin fails++; $display("FAIL reset_frame got %0b expected 0", frame); end
    @(negedge clk);
    tests++; if (digit !== 4'h9) begin fails++; $display("FAIL post_reset_digit got %0h expected 9", digit); end
    tests++; if (blank !== 1'b0) begin fails++; $display("FAIL post_reset_blank got %0b expected 0", blank); end
    tests++; if (dp !== 1'b1)    begin fails++; $display("FAIL post_reset_dp got %0b expected 1", dp); end
  endtask

  task automatic test_full_scan();
    int         frames;
    logic [2:0] e;
    value    = 32'h7654_3210;
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    do_reset();
    frames = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      e = 3'((c / 4) % 8);
      tests++; if (sel !== e) begin fails++; $display("FAIL scan_sel c=%0d got %0d expected %0d", c, sel, e); end
      tests++; if (digit !== {1'b0, e}) begin fails++; $display("FAIL scan_digit c=%0d got %0h expected %0h", c, digit, e); end
      tests++; if (blank !== 1'b0) begin fails++; $display("FAIL scan_blank c=%0d got %0b expected 0", c, blank); end
      tests++; if (frame !== ((c % 32) == 0)) begin fails++; $display("FAIL scan_frame c=%0d got %0b expected %0b", c, frame, (c % 32) == 0); end
      if (frame === 1'b1) frames++;
    end
    tests++; if (frames != 2) begin fails++; $display("FAIL scan_frame_count got %0d expected 2", frames); end
  endtask

  task automatic test_enable_mask();
    logic [2:0] cur;
    logic       fexp;
    value    = 32'h7654_3210;
    digit_en = 8'b1001_0010;
    dp_in    = 8'h00;
    exp_q    = {3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7, 3'd1};
    cur      = 3'd0;
    do_reset();
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (c < 4) begin
        tests++; if (sel !== 3'd0) begin fails++; $display("FAIL mask_start_sel c=%0d got %0d expected 0", c, sel); end
        tests++; if (blank !== 1'b1) begin fails++; $display("FAIL mask_start_blank c=%0d got %0b expected 1", c, blank); end
      end else begin
        if ((c % 4) == 0) cur = exp_q.pop_front();
        fexp = (c >= 16) && (((c - 4) % 12) == 0);
        tests++; if (sel !== cur) begin fails++; $display("FAIL mask_sel c=%0d got %0d expected %0d", c, sel, cur); end
        tests++; if (blank !== 1'b0) begin fails++; $display("FAIL mask_blank c=%0d got %0b expected 0", c, blank); end
        tests++; if (frame !== fexp) begin fails++; $display("FAIL mask_frame c=%0d got %0b expected %0b", c, frame, fexp); end
      end
    end
  endtask

  task automatic test_disable_all();
    value    = 32'h7654_3210;
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    do_reset();
    for (int c = 1; c <= 21; c++) @(negedge clk);
    tests++; if (sel !== 3'd5) begin fails++; $display("FAIL off_pre_sel got %0d expected 5", sel); end
    digit_en = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      tests++; if (sel !== 3'd5)   begin fails++; $display("FAIL off_sel c=%0d got %0d expected 5", c, sel); end
      tests++; if (blank !== 1'b1) begin fails++; $display("FAIL off_blank c=%0d got %0b expected 1", c, blank); end
      tests++; if (frame !== 1'b0) begin fails++; $display("FAIL off_frame c=%0d got %0b expected 0", c, frame); end
    end
  endtask

  task automatic test_reset_mid();
    value    = 32'h7654_3210;
    digit_en = 8'hFF;
    dp_in    = 8'hFF;
    do_reset();
    for (int c = 1; c <= 25; c++) @(negedge clk);
    tests++; if (sel !== 3'd6) begin fails++; $display("FAIL mid_pre_sel got %0d expected 6", sel); end
    do_reset();
    tests++; if (sel !== 3'd0)   begin fails++; $display("FAIL mid_sel got %0d expected 0", sel); end
    tests++; if (blank !== 1'b1) begin fails++; $display("FAIL mid_blank got %0b expected 1", blank); end
    tests++; if (dp !== 1'b0)    begin fails++; $display("FAIL mid_dp got %0b expected 0", dp); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++; if (sel !== ((c == 4) ? 3'd1 : 3'd0)) begin fails++; $display("FAIL mid_advance c=%0d got %0d expected %0d", c, sel, (c == 4) ? 1 : 0); end
    end
  endtask

  task automatic test_leading_zero();
    logic [2:0] e;
    logic       bexp;
    value    = 32'h0000_0120;
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      e = 3'((c / 4) % 8);
`ifdef LEADING_ZERO_BLANK_EN
      bexp = (e >= 3'd3);
`else
      bexp = 1'b0;
`endif
      tests++; if (blank !== bexp) begin fails++; $display("FAIL lz_blank c=%0d sel=%0d got %0b expected %0b", c, e, blank, bexp); end
    end
  endtask

  task automatic test_dp_value_change();
    logic [2:0] e;
    value    = 32'h7654_3210;
    digit_en = 8'hFF;
    dp_in    = 8'h04;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      e = 3'((c / 4) % 8);
      tests++; if (dp !== (e == 3'd2)) begin fails++; $display("FAIL dp_slot c=%0d got %0b expected %0b", c, dp, e == 3'd2); end
    end
    value = 32'hFFFF_FFFF;
    tests++; if (digit !== 4'h2) begin fails++; $display("FAIL chg_early got %0h expected 2", digit); end
    for (int c = 10; c <= 32; c++) begin
      @(negedge clk);
      e = 3'((c / 4) % 8);
      tests++; if (digit !== 4'hF) begin fails++; $display("FAIL chg_digit c=%0d got %0h expected f", c, digit); end
      tests++; if (dp !== (e == 3'd2)) begin fails++; $display("FAIL dp_slot c=%0d got %0b expected %0b", c, dp, e == 3'd2); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    value    = '0;
    digit_en = '0;
    dp_in    = '0;
    test_reset();
    test_full_scan();
    test_enable_mask();
    test_disable_all();
    test_reset_mid();
    test_leading_zero();
    test_dp_value_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
